eth_pkt_rr_arbiter: RTL
=======================

ETH_PKT_RR_ARBITER -- requirements
Module: eth_pkt_rr_arbiter

Interface
REQ-001 Parameter N, default 2, number of eth_pkt_if source ports; legal range 2..8.
REQ-002 Parameter GW, default $clog2(N), grant index width; derived, not overridden.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 pkt_i[N]  eth_pkt_if.i array  --  source ports (data 64, val, sop, eop, mod 3, ready returned).
REQ-006 pkt_o  eth_pkt_if.o  --  single shared sink port.
REQ-007 port_en_i  input  N  per-port grant enable; bit 0 = ignore that port at arbitration.
REQ-008 grant_o  output  GW  index of currently/last granted port.
REQ-009 busy_o  output  1  high while in XFER.
REQ-010 pkt_cnt_o  output  32  packets forwarded (eop accepted), wraps.
REQ-011 drop_cnt_o  output  16  orphan words flushed, saturates at 16'hFFFF.
REQ-012 sop_err_cnt_o  output  16  sop seen mid-packet on granted port, saturates.

Function
REQ-013 Two states: IDLE, XFER.
REQ-014 IDLE: pkt_o.val/sop/eop = 0, pkt_o.data = 0, pkt_o.mod = 0; busy_o = 0.
REQ-015 IDLE: candidate = port i with port_en_i[i] & pkt_i[i].val & pkt_i[i].sop.
REQ-016 IDLE: winner = first candidate scanning last+1, last+2, ... mod N, where last = last granted port.
REQ-017 Winner registered into grant; state -> XFER next cycle; no word transferred in the arbitration cycle (1-cycle arbitration latency).
REQ-018 IDLE, no candidate: stay IDLE, grant_o holds last.
REQ-019 IDLE: any enabled port with val=1 and sop=0 gets ready=1 (orphan flush) and each such port increments drop_cnt_o once per cycle (sum of flushed ports, saturating).
REQ-020 IDLE: ports not flushed get ready=0; disabled ports always ready=0.
REQ-021 XFER: pkt_o data/val/sop/eop/mod = pkt_i[grant] combinationally; pkt_i[grant].ready = pkt_o.ready; all other ready = 0.
REQ-022 XFER: word accepted when pkt_o.val & pkt_o.ready; mod passed unmodified (0 = 8 bytes valid, k = k bytes).
REQ-023 XFER: accepted word with eop -> IDLE next cycle, last <= grant, pkt_cnt_o += 1.
REQ-024 Single-word packet (sop & eop same word): 1 transfer cycle, then IDLE.
REQ-025 XFER: accepted word with sop, other than first word of packet -> sop_err_cnt_o += 1; word still forwarded, packet not terminated.
REQ-026 XFER: port_en_i deassert for granted port does not abort; packet completes.
REQ-027 XFER: val=0 or ready=0 -> no state change, counters hold.
REQ-028 Minimum 1 idle cycle between packets on pkt_o; max throughput per packet = L/(L+1) for L words.

Reset
REQ-029 rst_i high at clock edge: state IDLE, last = N-1 (port 0 wins first), grant_o = N-1, all counters 0.
REQ-030 rst_i mid-packet: packet abandoned, pkt_o.val = 0 from the cycle after the reset edge, no eop emitted.
REQ-031 During rst_i all pkt_i[*].ready = 0.

Structure
REQ-032 Shared package holds N limit constant, counter widths, and state enum typedef.
REQ-033 One sub-module: eth_pkt_rr_pick (combinational rotating-priority select, N requests + last -> winner index, found flag).
REQ-034 Counters, FSM, mux in top-level; no storage of packet data.

Verification
REQ-035 N=2, reset, both ports present 3-word packets -> port 0 sent first, 1 idle cycle, port 1 sent; pkt_cnt_o = 2; grant_o = 1.
REQ-036 N=4, all ports stream continuously -> grant order 0,1,2,3,0...; each word count and mod on pkt_o match source exactly.
REQ-037 Random pkt_o.ready (50%) during 5-word packet -> no word lost/duplicated; other ports ready = 0 throughout.
REQ-038 Port 1 sends val=1 sop=0 for 3 cycles in IDLE -> drop_cnt_o = 3, pkt_o.val stays 0.
REQ-039 Second sop at word 3 of granted packet -> sop_err_cnt_o = 1, all words forwarded, one eop.
REQ-040 rst_i pulsed at word 2 of 6-word packet -> pkt_o.val = 0 next cycle, counters 0, next grant to port 0.

Source files
------------

// File: rtl/eth_pkt_rr_arbiter_pkg.sv
// Shared definitions for the round-robin Ethernet packet arbiter.
// Holds the port-count limit, the eth_pkt_if field widths, the counter widths,
// the FSM state type and a saturating-add helper for the error counters.
package eth_pkt_rr_arbiter_pkg;

    localparam int ARB_N_MAX     = 8;   // largest supported number of source ports
    localparam int DATA_W        = 64;
    localparam int MOD_W         = 3;
    localparam int PKT_CNT_W     = 32;
    localparam int DROP_CNT_W    = 16;
    localparam int SOP_ERR_CNT_W = 16;
    localparam int FLUSH_CNT_W   = $clog2(ARB_N_MAX + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    // 16-bit saturating add; the increment never exceeds the port count.
    function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                              input logic [FLUSH_CNT_W-1:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + 17'(b);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/eth_pkt_if.sv
// Ethernet packet word stream: 64-bit data, val/sop/eop framing, mod = number of
// valid bytes on the word (0 means all 8), ready flows back from the sink.
// Modport i: arbiter-side view of a source (arbiter consumes, returns ready).
// Modport o: arbiter-side view of the sink (arbiter produces, receives ready).
interface eth_pkt_if;
    import eth_pkt_rr_arbiter_pkg::*;

    logic [DATA_W-1:0] data;
    logic              val;
    logic              sop;
    logic              eop;
    logic [MOD_W-1:0]  mod;
    logic              ready;

    modport i (input data, val, sop, eop, mod, output ready);
    modport o (output data, val, sop, eop, mod, input ready);

endinterface

// File: rtl/eth_pkt_rr_pick.sv
// Rotating-priority picker. Scans req starting at last+1 (mod N) and returns
// the first set index.
//   req   : per-port request bits
//   last  : most recently granted port (lowest priority this round)
//   win   : winning port index (0 when found is low)
//   found : at least one request was set
module eth_pkt_rr_pick #(
    parameter int N  = 2,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last,
    output logic [GW-1:0] win,
    output logic          found
);

    logic [GW-1:0] idx;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = GW'((int'(last) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

endmodule

// File: rtl/eth_pkt_rr_arbiter.sv
// Round-robin packet arbiter: N eth_pkt_if sources share one sink, whole packets
// at a time. One arbitration cycle precedes each packet; while idle, stray
// mid-packet words on enabled ports are flushed and counted.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   pkt_i[N]       : source ports
//   pkt_o          : shared sink port
//   port_en_i      : per-port arbitration enable
//   grant_o        : current / last granted port
//   busy_o         : a packet is in transfer
//   pkt_cnt_o      : packets forwarded (wraps)
//   drop_cnt_o     : orphan words flushed (saturates)
//   sop_err_cnt_o  : sop seen after the first word of a packet (saturates)
module eth_pkt_rr_arbiter
    import eth_pkt_rr_arbiter_pkg::*;
#(
    parameter  int N  = 2,
    localparam int GW = $clog2(N)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    eth_pkt_if.i                     pkt_i [N],
    eth_pkt_if.o                     pkt_o,
    input  logic [N-1:0]             port_en_i,
    output logic [GW-1:0]            grant_o,
    output logic                     busy_o,
    output logic [PKT_CNT_W-1:0]     pkt_cnt_o,
    output logic [DROP_CNT_W-1:0]    drop_cnt_o,
    output logic [SOP_ERR_CNT_W-1:0] sop_err_cnt_o
);

    // Flattened view of the source interface array so it can be indexed by grant.
    logic [N-1:0][DATA_W-1:0] src_data;
    logic [N-1:0][MOD_W-1:0]  src_mod;
    logic [N-1:0]             src_val, src_sop, src_eop, src_rdy;

    for (genvar g = 0; g < N; g++) begin : g_src
        assign src_data[g]    = pkt_i[g].data;
        assign src_val[g]     = pkt_i[g].val;
        assign src_sop[g]     = pkt_i[g].sop;
        assign src_eop[g]     = pkt_i[g].eop;
        assign src_mod[g]     = pkt_i[g].mod;
        assign pkt_i[g].ready = src_rdy[g];
    end

    arb_state_e               state, state_nxt;
    logic [GW-1:0]            grant;
    logic                     mid_pkt;      // first word of the packet already accepted
    logic [PKT_CNT_W-1:0]     pkt_cnt;
    logic [DROP_CNT_W-1:0]    drop_cnt;
    logic [SOP_ERR_CNT_W-1:0] sop_err_cnt;

    logic [N-1:0]             cand, flush;
    logic [FLUSH_CNT_W-1:0]   flush_cnt;
    logic [GW-1:0]            win;
    logic                     found;

    logic [DATA_W-1:0]        out_data;
    logic [MOD_W-1:0]         out_mod;
    logic                     out_val, out_sop, out_eop;
    logic                     acc;

    assign cand      = port_en_i & src_val & src_sop;
    assign flush     = port_en_i & src_val & ~src_sop;
    assign flush_cnt = FLUSH_CNT_W'($countones(flush));

    eth_pkt_rr_pick #(.N(N), .GW(GW)) u_pick (
        .req   (cand),
        .last  (grant),
        .win   (win),
        .found (found)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (found) state_nxt = ST_XFER;
            ST_XFER: if (acc && out_eop) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: sink mux and ready steering. Everything is held off while reset is
    // asserted so a sink can never accept a word the source does not see consumed.
    always_comb begin
        out_data = '0;
        out_mod  = '0;
        out_val  = 1'b0;
        out_sop  = 1'b0;
        out_eop  = 1'b0;
        src_rdy  = '0;
        if (!rst_i) begin
            case (state)
                ST_IDLE: src_rdy = flush;
                ST_XFER: begin
                    out_data       = src_data[grant];
                    out_mod        = src_mod[grant];
                    out_val        = src_val[grant];
                    out_sop        = src_sop[grant];
                    out_eop        = src_eop[grant];
                    src_rdy[grant] = pkt_o.ready;
                end
                default: ;
            endcase
        end
    end

    assign acc = out_val & pkt_o.ready;

    // Grant and counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant       <= GW'(N - 1);
            mid_pkt     <= 1'b0;
            pkt_cnt     <= '0;
            drop_cnt    <= '0;
            sop_err_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    drop_cnt <= sat_add16(drop_cnt, flush_cnt);
                    mid_pkt  <= 1'b0;
                    if (found) grant <= win;
                end
                ST_XFER: if (acc) begin
                    mid_pkt <= 1'b1;
                    if (out_sop && mid_pkt)
                        sop_err_cnt <= sat_add16(sop_err_cnt, FLUSH_CNT_W'(1));
                    if (out_eop)
                        pkt_cnt <= pkt_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pkt_o.data    = out_data;
    assign pkt_o.mod     = out_mod;
    assign pkt_o.val     = out_val;
    assign pkt_o.sop     = out_sop;
    assign pkt_o.eop     = out_eop;
    assign grant_o       = grant;
    assign busy_o        = (state == ST_XFER);
    assign pkt_cnt_o     = pkt_cnt;
    assign drop_cnt_o    = drop_cnt;
    assign sop_err_cnt_o = sop_err_cnt;

endmodule
